// File: rtl/alu_result_checker.sv
// Recomputes ALU result/flags from a staged beat and compares against the ALU; 2-edge latency,
// one beat per cycle, no backpressure (beats arriving while halted are ignored).
module alu_result_checker #(
  parameter int WIDTH         = 64,
  parameter int CNT_W         = 32,
  parameter int STOP_ON_ERROR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic [WIDTH-1:0] result,
  input  logic             negative,
  input  logic             zero,
  input  logic             overflow,
  input  logic             carry_out,
  output logic             check_valid,
  output logic             mismatch,
  output logic [3:0]       mismatch_reason,
  output logic             illegal_op,
  output logic [CNT_W-1:0] checked_count,
  output logic [CNT_W-1:0] error_count,
  output logic             halted,
  output logic             first_err_valid,
  output logic [2:0]       first_err_cntrl,
  output logic [WIDTH-1:0] first_err_A,
  output logic [WIDTH-1:0] first_err_B,
  output logic [WIDTH-1:0] first_err_result,
  output logic [WIDTH-1:0] first_err_expected
);

  typedef struct packed {
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             n;
    logic             z;
    logic             v;
    logic             c;
  } beat_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t           state;
  logic             stg_vld;
  beat_t            stg;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] exp_res;
  logic             exp_v;
  logic             exp_c;
  logic             arith;
  logic             ill;
  logic [3:0]       rsn;
  logic             fail;
  logic             report;

  assign add_w = {1'b0, stg.a} + {1'b0, stg.b};
  assign sub_w = {1'b0, stg.a} + {1'b0, ~stg.b} + (WIDTH+1)'(1);

  always_comb begin
    exp_res = '0;
    exp_v   = 1'b0;
    exp_c   = 1'b0;
    arith   = 1'b0;
    ill     = 1'b0;
    case (stg.cntrl)
      3'b000: exp_res = stg.b;
      3'b010: begin
        exp_res = add_w[WIDTH-1:0];
        exp_c   = add_w[WIDTH];
        exp_v   = (stg.a[WIDTH-1] == stg.b[WIDTH-1]) && (add_w[WIDTH-1] != stg.a[WIDTH-1]);
        arith   = 1'b1;
      end
      3'b011: begin
        exp_res = sub_w[WIDTH-1:0];
        exp_c   = sub_w[WIDTH];
        exp_v   = (stg.a[WIDTH-1] != stg.b[WIDTH-1]) && (sub_w[WIDTH-1] != stg.a[WIDTH-1]);
        arith   = 1'b1;
      end
      3'b100:  exp_res = stg.a & stg.b;
      3'b101:  exp_res = stg.a | stg.b;
      3'b110:  exp_res = stg.a ^ stg.b;
      default: ill = 1'b1;
    endcase
  end

  // Illegal ops report no per-field reasons; they count as failures on their own.
  always_comb begin
    rsn = '0;
    if (!ill) begin
      rsn[0] = (stg.result != exp_res);
      rsn[1] = (stg.n != exp_res[WIDTH-1]) || (stg.z != (exp_res == '0));
      rsn[2] = arith && (stg.v != exp_v);
      rsn[3] = arith && (stg.c != exp_c);
    end
  end

  assign fail   = ill || (|rsn);
  assign report = stg_vld && (state == RUN);
  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state              <= RUN;
      stg_vld            <= 1'b0;
      stg                <= '0;
      check_valid        <= 1'b0;
      mismatch           <= 1'b0;
      mismatch_reason    <= '0;
      illegal_op         <= 1'b0;
      checked_count      <= '0;
      error_count        <= '0;
      first_err_valid    <= 1'b0;
      first_err_cntrl    <= '0;
      first_err_A        <= '0;
      first_err_B        <= '0;
      first_err_result   <= '0;
      first_err_expected <= '0;
    end else begin
      check_valid <= report;
      stg_vld     <= in_valid && (state == RUN);
      if (in_valid && (state == RUN))
        stg <= '{cntrl: cntrl, a: A, b: B, result: result,
                 n: negative, z: zero, v: overflow, c: carry_out};
      if (report) begin
        mismatch        <= |rsn;
        mismatch_reason <= rsn;
        illegal_op      <= ill;
        if (checked_count != '1)
          checked_count <= checked_count + CNT_W'(1);
        if (fail && (error_count != '1))
          error_count <= error_count + CNT_W'(1);
        if (fail && !first_err_valid) begin
          first_err_valid    <= 1'b1;
          first_err_cntrl    <= stg.cntrl;
          first_err_A        <= stg.a;
          first_err_B        <= stg.b;
          first_err_result   <= stg.result;
          first_err_expected <= ill ? '0 : exp_res;
        end
        if (fail && (STOP_ON_ERROR != 0))
          state <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized bench: three checker instances (default, stop-on-error, 4-bit counters) share stimulus
// and are compared every cycle against a beat-level arithmetic reference model.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid;
  logic [63:0] A, B, result;
  logic [2:0]  cntrl;
  logic        negative, zero, overflow, carry_out;

  logic [2:0]       cv, mm, il, hl, fev;
  logic [2:0][3:0]  rs;
  logic [2:0][2:0]  fec;
  logic [2:0][63:0] fea, feb, fer, fee;
  logic [31:0]      cc0, cc1, ec0, ec1;
  logic [3:0]       cc2, ec2;

  int checks = 0;
  int failures = 0;
  int pulses0 = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.WIDTH(64), .CNT_W(32), .STOP_ON_ERROR(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .A(A), .B(B), .cntrl(cntrl),
    .result(result), .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .check_valid(cv[0]), .mismatch(mm[0]), .mismatch_reason(rs[0]), .illegal_op(il[0]),
    .checked_count(cc0), .error_count(ec0), .halted(hl[0]), .first_err_valid(fev[0]),
    .first_err_cntrl(fec[0]), .first_err_A(fea[0]), .first_err_B(feb[0]),
    .first_err_result(fer[0]), .first_err_expected(fee[0]));

  alu_result_checker #(.WIDTH(64), .CNT_W(32), .STOP_ON_ERROR(1)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .A(A), .B(B), .cntrl(cntrl),
    .result(result), .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .check_valid(cv[1]), .mismatch(mm[1]), .mismatch_reason(rs[1]), .illegal_op(il[1]),
    .checked_count(cc1), .error_count(ec1), .halted(hl[1]), .first_err_valid(fev[1]),
    .first_err_cntrl(fec[1]), .first_err_A(fea[1]), .first_err_B(feb[1]),
    .first_err_result(fer[1]), .first_err_expected(fee[1]));

  alu_result_checker #(.WIDTH(64), .CNT_W(4), .STOP_ON_ERROR(0)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .A(A), .B(B), .cntrl(cntrl),
    .result(result), .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .check_valid(cv[2]), .mismatch(mm[2]), .mismatch_reason(rs[2]), .illegal_op(il[2]),
    .checked_count(cc2), .error_count(ec2), .halted(hl[2]), .first_err_valid(fev[2]),
    .first_err_cntrl(fec[2]), .first_err_A(fea[2]), .first_err_B(feb[2]),
    .first_err_result(fer[2]), .first_err_expected(fee[2]));

  // Reference model state, one slot per instance
  logic [31:0] cnt_max [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
  logic        stop_on [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] m_chk [3], m_err [3];
  logic        m_halt [3], m_fev [3], pend_vld [3];
  logic [2:0]  m_fec [3];
  logic [63:0] m_fea [3], m_feb [3], m_fer [3], m_fee [3];
  logic [2:0]  p_op;
  logic [63:0] p_a, p_b, p_res;
  logic        p_n, p_z, p_v, p_c;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected result and V/C from the true (unbounded) arithmetic value.
  task automatic ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic ill, output logic [63:0] e, output logic ov, output logic cy);
    logic [127:0] sa, sb, sw;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ill = 1'b0; ov = 1'b0; cy = 1'b0; e = '0;
    case (op)
      3'd0: e = b;
      3'd2: begin e = a + b; cy = (e < a);  sw = sa + sb; ov = (sw != {{64{e[63]}}, e}); end
      3'd3: begin e = a - b; cy = (a >= b); sw = sa - sb; ov = (sw != {{64{e[63]}}, e}); end
      3'd4: e = a & b;
      3'd5: e = a | b;
      3'd6: e = a ^ b;
      default: ill = 1'b1;
    endcase
  endtask

  task automatic step(input logic rst, input logic clr, input logic v, input logic [2:0] op,
                      input logic [63:0] ia, input logic [63:0] ib, input logic [63:0] ires,
                      input logic in_n, input logic in_z, input logic in_v, input logic in_c);
    logic ill, ov, cy, arith, ecv, h0, fl;
    logic [63:0] e;
    logic [3:0] rsn;
    logic [31:0] gcc, gec;
    reset = rst; clear = clr; in_valid = v; cntrl = op; A = ia; B = ib; result = ires;
    negative = in_n; zero = in_z; overflow = in_v; carry_out = in_c;
    @(posedge clk);
    #1;
    if (cv[0]) pulses0++;
    ref_op(p_op, p_a, p_b, ill, e, ov, cy);
    arith = (p_op == 3'd2) || (p_op == 3'd3);
    rsn = ill ? 4'b0 : {arith && (p_c != cy), arith && (p_v != ov),
                        (p_n != e[63]) || (p_z != (e == 64'd0)), p_res != e};
    fl = ill || (rsn != 4'b0);
    for (int d = 0; d < 3; d++) begin
      ecv = 1'b0;
      if (rst || clr) begin
        m_chk[d] = 0; m_err[d] = 0; m_halt[d] = 0; m_fev[d] = 0; pend_vld[d] = 0;
        m_fec[d] = 0; m_fea[d] = 0; m_feb[d] = 0; m_fer[d] = 0; m_fee[d] = 0;
      end else begin
        h0 = m_halt[d];
        ecv = pend_vld[d] && !h0;
        if (ecv) begin
          if (m_chk[d] != cnt_max[d]) m_chk[d]++;
          if (fl && m_err[d] != cnt_max[d]) m_err[d]++;
          if (fl && !m_fev[d]) begin
            m_fev[d] = 1; m_fec[d] = p_op; m_fea[d] = p_a; m_feb[d] = p_b; m_fer[d] = p_res;
            m_fee[d] = ill ? 64'd0 : e;
          end
          if (fl && stop_on[d]) m_halt[d] = 1;
        end
        pend_vld[d] = v && !h0;
      end
      gcc = (d == 0) ? cc0 : (d == 1) ? cc1 : {28'd0, cc2};
      gec = (d == 0) ? ec0 : (d == 1) ? ec1 : {28'd0, ec2};
      check($sformatf("d%0d_check_valid", d), 64'(cv[d]), 64'(ecv));
      if (ecv) begin
        check($sformatf("d%0d_mismatch", d), 64'(mm[d]), 64'(rsn != 4'b0));
        check($sformatf("d%0d_reason", d), 64'(rs[d]), 64'(rsn));
        check($sformatf("d%0d_illegal", d), 64'(il[d]), 64'(ill));
      end
      check($sformatf("d%0d_checked_count", d), 64'(gcc), 64'(m_chk[d]));
      check($sformatf("d%0d_error_count", d), 64'(gec), 64'(m_err[d]));
      check($sformatf("d%0d_halted", d), 64'(hl[d]), 64'(m_halt[d]));
      check($sformatf("d%0d_first_err_valid", d), 64'(fev[d]), 64'(m_fev[d]));
      if (m_fev[d]) begin
        check($sformatf("d%0d_fe_cntrl", d), 64'(fec[d]), 64'(m_fec[d]));
        check($sformatf("d%0d_fe_A", d), fea[d], m_fea[d]);
        check($sformatf("d%0d_fe_B", d), feb[d], m_feb[d]);
        check($sformatf("d%0d_fe_result", d), fer[d], m_fer[d]);
        check($sformatf("d%0d_fe_expected", d), fee[d], m_fee[d]);
      end
    end
    p_op = op; p_a = ia; p_b = ib; p_res = ires; p_n = in_n; p_z = in_z; p_v = in_v; p_c = in_c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] x;
    case ($urandom_range(0, 7))
      0: x = 64'd0;
      1: x = 64'hFFFF_FFFF_FFFF_FFFF;
      2: x = 64'h7FFF_FFFF_FFFF_FFFF;
      3: x = 64'h8000_0000_0000_0000;
      default: x = {$urandom, $urandom};
    endcase
    return x;
  endfunction

  // corrupt: 0 none, 1 result bit, 2 negative, 3 overflow, 4 carry
  task automatic rand_beat(input logic clr, input logic [2:0] op, input int corrupt);
    logic [63:0] a, b, e, r;
    logic ill, ov, cy, n, z, v, c;
    a = rand_operand();
    b = rand_operand();
    ref_op(op, a, b, ill, e, ov, cy);
    r = e; n = e[63]; z = (e == 64'd0);
    v = ((op == 3'd2) || (op == 3'd3)) ? ov : 1'($urandom);
    c = ((op == 3'd2) || (op == 3'd3)) ? cy : 1'($urandom);
    case (corrupt)
      1: r[$urandom_range(0, 63)] = ~r[$urandom_range(0, 63)];
      2: n = ~n;
      3: v = ~v;
      4: c = ~c;
      default: ;
    endcase
    if (corrupt == 1 && r == e) r = ~e;
    step(0, clr, 1, op, a, b, r, n, z, v, c);
  endtask

  function automatic logic [2:0] legal_op();
    logic [2:0] ops [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    return ops[$urandom_range(0, 5)];
  endfunction

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  initial begin
    p_op = 0; p_a = 0; p_b = 0; p_res = 0; p_n = 0; p_z = 0; p_v = 0; p_c = 0;
    step(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 3'd2, 1, 1, 2, 0, 0, 0, 0);
    idle(1);

    // Directed arithmetic corner cases
    step(0, 0, 1, 3'd2, 64'd1, 64'd1, 64'd2, 0, 0, 0, 0);
    step(0, 0, 1, 3'd2, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0);
    step(0, 0, 1, 3'd2, MAXP, MAXP, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
    step(0, 0, 1, 3'd3, MAXP, MINN, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0);
    step(0, 0, 1, 3'd3, MAXP, MINN, 64'd0, 0, 1, 1, 0);
    step(0, 0, 1, 3'd0, MAXP, 64'd0, 64'd0, 0, 1, 1, 1);
    step(0, 0, 1, 3'd4, MAXP, MINN, 64'd0, 0, 1, 0, 0);
    idle(2);
    check("dir_first_err_expected", fee[0], 64'hFFFF_FFFF_FFFF_FFFE);
    check("dir_error_count", 64'(ec0), 64'd2);
    check("dir_checked_count", 64'(cc0), 64'd7);
    check("dir_stop_halted", 64'(hl[1]), 64'd1);
    check("dir_stop_checked", 64'(cc1), 64'd3);

    // Clear wins over a simultaneous beat; then illegal op with stop-on-error
    rand_beat(1, legal_op(), 0);
    idle(2);
    check("clr_drop_checked", 64'(cc0), 64'd0);
    step(0, 0, 1, 3'd1, 64'd5, 64'd6, 64'd11, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) rand_beat(0, legal_op(), 0);
    idle(2);
    check("ill_halted", 64'(hl[1]), 64'd1);
    check("ill_error_count", 64'(ec1), 64'd1);
    check("ill_checked_frozen", 64'(cc1), 64'd1);
    check("ill_fe_expected", fee[1], 64'd0);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    check("clr_halted", 64'(hl[1]), 64'd0);
    check("clr_fev", 64'(fev[1]), 64'd0);
    check("clr_err", 64'(ec1), 64'd0);

    // Back-to-back correct beats
    pulses0 = 0;
    for (int i = 0; i < 100; i++) rand_beat(0, legal_op(), 0);
    idle(2);
    check("b2b_pulses", 64'(pulses0), 64'd100);
    check("b2b_checked", 64'(cc0), 64'd100);
    check("b2b_errors", 64'(ec0), 64'd0);

    // Saturation of the narrow counter
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) rand_beat(0, legal_op(), 1);
    idle(2);
    check("sat_err_narrow", 64'(ec2), 64'd15);
    check("sat_chk_narrow", 64'(cc2), 64'd15);
    check("sat_err_wide", 64'(ec0), 64'd20);

    // Reset while a beat is staged
    pulses0 = 0;
    rand_beat(0, legal_op(), 0);
    step(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    check("rst_midflight_pulses", 64'(pulses0), 64'd0);

    // Mixed random traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 19);
      op = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd7) : legal_op();
      if (r == 0) rand_beat(1, op, 0);
      else if (r <= 3) idle(1);
      else rand_beat(0, op, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- On-chip checker for the 64-bit ALU. It sits on the ALU's output side, opposite the stimulus source.
- Each valid beat delivers operands, control, result and four flags. The block recomputes the expected result and flags, compares them against what the ALU returned, and keeps pass/error counts.
- It also captures the first failing transaction, for use in processor bring-up and self-test.

Parameters:
WIDTH, 64, operand/result width
CNT_W, 32, width of checked/error counters
STOP_ON_ERROR, 0, 1 = halt checking after first error until clear

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous clear of counters, capture registers and halt state
in_valid  input  1  beat qualifier for the inputs below
A  input  WIDTH  ALU operand A
B  input  WIDTH  ALU operand B
cntrl  input  3  op: 000 pass B, 010 add, 011 sub (A-B), 100 and, 101 or, 110 xor
result  input  WIDTH  ALU result
negative, zero, overflow, carry_out  input  1 each  ALU flags
check_valid  output  1  one-cycle pulse: a beat finished checking
mismatch  output  1  qualified by check_valid: beat failed
mismatch_reason  output  4  bit0 result, bit1 negative/zero, bit2 overflow, bit3 carry
illegal_op  output  1  qualified by check_valid: cntrl was 001 or 111
checked_count  output  CNT_W  beats checked, saturating
error_count  output  CNT_W  failing beats (mismatch or illegal), saturating
halted  output  1  state is HALT
first_err_valid  output  1  capture registers hold a failure
first_err_cntrl  output  3  cntrl of first failure
first_err_A, first_err_B, first_err_result, first_err_expected  output  WIDTH each  first failure data

Behaviour:
- Reset and clear: all outputs go to 0, the stage register is invalidated, and state goes to RUN.
- Clear has priority over in_valid in the same cycle; that beat is dropped.
- Reset or clear mid-flight discards the staged beat; no check_valid is produced for it.
- Pipeline:
  - Edge k: in_valid=1 in RUN registers A, B, cntrl, result and flags into the stage register.
  - The expected values are computed combinationally from the stage register.
  - Edge k+1: check_valid, mismatch, mismatch_reason, illegal_op and both counters update.
  - Latency is 2 edges. Throughput is one beat per cycle, with no backpressure.
- Expected result:
  - Pass B: B. Add: A+B. Sub: A+~B+1. And, or, xor: bitwise.
  - All arithmetic is mod 2^WIDTH.
- Expected flags:
  - negative = exp[WIDTH-1].
  - zero = (exp==0).
  - Add: carry = carry-out of A+B; overflow = (A[msb]==B[msb]) && (exp[msb]!=A[msb]).
  - Sub: carry = carry-out of A+~B+1 (1 = no borrow); overflow = (A[msb]!=B[msb]) && (exp[msb]!=A[msb]).
  - overflow and carry_out are ignored for pass, and, or, xor: reason bits 2 and 3 are forced 0.
- Illegal cntrl (001, 111):
  - illegal_op=1, mismatch=0, reason=0.
  - error_count increments and checked_count increments.
- Counters saturate at all-ones and never wrap.
- First-error capture:
  - Loads only when first_err_valid=0 and the beat fails (mismatch or illegal).
  - Holds until reset or clear.
  - first_err_expected = 0 for an illegal op.
- State machine: RUN, HALT.
  - RUN to HALT: on the edge where a failing beat is reported, if STOP_ON_ERROR=1.
  - In HALT, in_valid is ignored, counters are frozen and halted=1.
  - HALT to RUN only on clear or reset.
  - With STOP_ON_ERROR=0, HALT is unreachable.
- Simultaneous events: a beat reported in the same edge as clear is discarded; clear wins.

Test Plan:
- ADD A=1, B=1, result=2, flags 0000 -> one edge later check_valid=1, mismatch=0, checked_count=1, error_count=0.
- ADD A=B=7FFF_FFFF_FFFF_FFFF, result=FFFF_FFFF_FFFF_FFFE, negative=1, overflow=1, carry_out=0 -> no mismatch. Repeat with overflow=0 -> mismatch=1, reason=0100, error_count=1, first_err_expected=FFFF_FFFF_FFFF_FFFE.
- SUB A=7FFF_FFFF_FFFF_FFFF, B=8000_0000_0000_0000, result=FFFF_FFFF_FFFF_FFFF, negative=1, overflow=1, carry_out=0 -> pass. Wrong result 0 -> reason=0011 (result and N/Z; expected flags derive from expected result).
- PASS_B with B=0, result=0, zero=1, overflow=1, carry_out=1 -> pass (V/C ignored). AND A=7FFF_FFFF_FFFF_FFFF, B=8000_0000_0000_0000, result=0, zero=1 -> pass.
- STOP_ON_ERROR=1, cntrl=001 -> illegal_op=1, halted=1, error_count=1. Then 5 more valid beats -> counts unchanged. Then clear -> counts 0, halted=0, first_err_valid=0.
- 100 back-to-back random correct beats (in_valid held high) -> 100 check_valid pulses, checked_count=100. With CNT_W=4, 20 failing beats -> error_count=15 (saturated). Assert reset during a staged beat -> no check_valid pulse for it.
